strobe_sequencer: RTL and testbench

- Sequences the IR LED strobe for each camera exposure: on a frame-start trigger, waits a programmable delay, drives the strobe for a programmable width, then enforces a hold-off before re-arming.
- Sits between sensor frame-timing logic and the LED driver pin.
- Time bases are built from down-counting phase counters, one phase at a time, with load/enable control.
- Drives busy/done status to the capture control logic.

---
 rtl/strobe_seq_pkg.sv | 37 +++
 rtl/phase_counter.sv | 41 ++++
 rtl/strobe_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_strobe_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/strobe_seq_pkg.sv
// strobe_seq_pkg
// Shared definitions for the IR LED strobe sequencer:
//   - state_e     : sequencer states (IDLE=0, DELAY=1, STROBE=2, HOLDOFF=3)
//   - CNT_W_DEF   : default width of delay/width/hold-off fields
//   - MISS_W_DEF  : default width of the missed-trigger counter
//   - first_phase : picks the first phase with a nonzero length
package strobe_seq_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int MISS_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    STROBE  = 2'd2,
    HOLDOFF = 2'd3
  } state_e;

  // Phases run in the fixed order DELAY, STROBE, HOLDOFF; zero-length
  // phases are skipped entirely. IDLE means nothing is left to run.
  function automatic state_e first_phase(input logic d_nz,
                                         input logic w_nz,
                                         input logic h_nz);
    state_e res;
    if (d_nz) begin
      res = DELAY;
    end else if (w_nz) begin
      res = STROBE;
    end else if (h_nz) begin
      res = HOLDOFF;
    end else begin
      res = IDLE;
    end
    return res;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// phase_counter
// Loadable down-counter used as the time base for every sequencer phase.
// Ports:
//   clock  in        rising-edge clock
//   reset  in        asynchronous active-high clear
//   load   in        load din (takes priority over enable)
//   din    in CNT_W  load value
//   enable in        decrement by one; holds at zero
//   zero   out       counter value is zero
//   dout   out CNT_W current counter value
module phase_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] din,
  input  logic             enable,
  output logic             zero,
  output logic [CNT_W-1:0] dout
);

  logic [CNT_W-1:0] cnt_r;

  // Count register: load wins, otherwise decrement and stick at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= din;
    end else if (enable && (cnt_r != '0)) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign dout = cnt_r;
  assign zero = (cnt_r == '0);

endmodule

// File: rtl/strobe_sequencer.sv
// strobe_sequencer
// Sequences the IR LED strobe for each camera exposure. An accepted
// frame-start trigger runs DELAY (D cycles), STROBE (W cycles) and
// HOLDOFF (H cycles), skipping zero-length phases, then returns to IDLE
// with a one-cycle done pulse. A trigger in the done cycle is accepted,
// so sequences can run back to back.
// Ports:
//   clock        in          rising-edge clock
//   reset        in          asynchronous active-high reset
//   enable       in          1 = triggers accepted in IDLE
//   abort        in          synchronous abort of any sequence
//   trigger      in          single-cycle frame-start pulse
//   cfg_delay    in  CNT_W   cycles from trigger to strobe rise
//   cfg_width    in  CNT_W   strobe high cycles
//   cfg_holdoff  in  CNT_W   cycles after strobe fall before re-arm
//   strobe       out         registered LED strobe
//   busy         out         registered, high in every non-IDLE state
//   done         out         registered one-cycle completion pulse
//   miss_count   out MISS_W  saturating count of dropped triggers
// Optional feature: define STROBE_SEQ_MISS_CNT_EN to implement the
// missed-trigger counter; otherwise miss_count is tied to zero.
module strobe_sequencer
  import strobe_seq_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int MISS_W = MISS_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              abort,
  input  logic              trigger,
  input  logic [CNT_W-1:0]  cfg_delay,
  input  logic [CNT_W-1:0]  cfg_width,
  input  logic [CNT_W-1:0]  cfg_holdoff,
  output logic              strobe,
  output logic              busy,
  output logic              done,
  output logic [MISS_W-1:0] miss_count
);

  state_e           state_r;
  state_e           next_s;
  state_e           target_s;
  logic             entering_s;
  logic             accept_s;
  logic             done_s;
  logic             cnt_load_s;
  logic [CNT_W-1:0] cnt_din_s;
  logic             cnt_en_s;
  logic             cnt_zero_s;
  logic [CNT_W-1:0] cnt_dout_s;
  logic [CNT_W-1:0] w_r;
  logic [CNT_W-1:0] h_r;
  logic             strobe_r;
  logic             busy_r;
  logic             done_r;

  // D is consumed at acceptance, so only W and H need to be held.
  phase_counter #(.CNT_W(CNT_W)) u_phase_counter (
    .clock  (clock),
    .reset  (reset),
    .load   (cnt_load_s),
    .din    (cnt_din_s),
    .enable (cnt_en_s),
    .zero   (cnt_zero_s),
    .dout   (cnt_dout_s)
  );

  assign cnt_en_s = (state_r != IDLE) && (cnt_dout_s != '0);

  // Next-state logic: phase sequencing, counter load value and done pulse.
  always_comb begin
    next_s     = state_r;
    target_s   = IDLE;
    entering_s = 1'b0;
    accept_s   = 1'b0;
    done_s     = 1'b0;
    cnt_load_s = 1'b0;
    cnt_din_s  = '0;
    if (abort) begin
      next_s     = IDLE;
      cnt_load_s = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (trigger && enable) begin
            accept_s   = 1'b1;
            entering_s = 1'b1;
            target_s   = first_phase(|cfg_delay, |cfg_width, |cfg_holdoff);
          end else begin
            entering_s = 1'b0;
          end
        end
        DELAY: begin
          if (cnt_zero_s) begin
            entering_s = 1'b1;
            target_s   = first_phase(1'b0, |w_r, |h_r);
          end else begin
            entering_s = 1'b0;
          end
        end
        STROBE: begin
          if (cnt_zero_s) begin
            entering_s = 1'b1;
            target_s   = first_phase(1'b0, 1'b0, |h_r);
          end else begin
            entering_s = 1'b0;
          end
        end
        HOLDOFF: begin
          if (cnt_zero_s) begin
            entering_s = 1'b1;
            target_s   = IDLE;
          end else begin
            entering_s = 1'b0;
          end
        end
        default: begin
          next_s     = IDLE;
          cnt_load_s = 1'b1;
        end
      endcase
      // A phase of N cycles loads N-1 and leaves when the counter reads 0.
      if (entering_s) begin
        next_s     = target_s;
        cnt_load_s = 1'b1;
        case (target_s)
          DELAY:   cnt_din_s = cfg_delay - CNT_W'(1);
          STROBE:  cnt_din_s = (accept_s ? cfg_width : w_r) - CNT_W'(1);
          HOLDOFF: cnt_din_s = (accept_s ? cfg_holdoff : h_r) - CNT_W'(1);
          default: done_s = 1'b1;
        endcase
      end else begin
        cnt_din_s = '0;
      end
    end
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      w_r      <= '0;
      h_r      <= '0;
      strobe_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= next_s;
      strobe_r <= (next_s == STROBE);
      busy_r   <= (next_s != IDLE);
      done_r   <= done_s;
      if (accept_s) begin
        w_r <= cfg_width;
        h_r <= cfg_holdoff;
      end else begin
        w_r <= w_r;
        h_r <= h_r;
      end
    end
  end

  assign strobe = strobe_r;
  assign busy   = busy_r;
  assign done   = done_r;

`ifdef STROBE_SEQ_MISS_CNT_EN
  logic [MISS_W-1:0] miss_r;
  logic              miss_inc_s;

  // Abort wins over a same-cycle trigger, so such a trigger is not a miss.
  assign miss_inc_s = trigger && (state_r != IDLE) && !abort;

  // Saturating dropped-trigger counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      miss_r <= '0;
    end else if (miss_inc_s && (miss_r != {MISS_W{1'b1}})) begin
      miss_r <= miss_r + MISS_W'(1);
    end else begin
      miss_r <= miss_r;
    end
  end

  assign miss_count = miss_r;
`else
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_strobe_sequencer.sv
// tb_strobe_sequencer
// Directed self-checking bench for strobe_sequencer. Inputs change 1ns
// after each rising edge and outputs are checked at the same point, so
// every check observes the state left by the preceding edge.
module tb_strobe_sequencer;

  localparam int CNT_W  = 16;
  localparam int MISS_W = 8;
`ifdef STROBE_SEQ_MISS_CNT_EN
  localparam bit MEN = 1'b1;
`else
  localparam bit MEN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic              abort;
  logic              trigger;
  logic [CNT_W-1:0]  cfg_delay;
  logic [CNT_W-1:0]  cfg_width;
  logic [CNT_W-1:0]  cfg_holdoff;
  logic              strobe;
  logic              busy;
  logic              done;
  logic [MISS_W-1:0] miss_count;

  int errors   = 0;
  int checks   = 0;
  int exp_miss = 0;

  always #5 clock = ~clock;

  strobe_sequencer #(.CNT_W(CNT_W), .MISS_W(MISS_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .abort       (abort),
    .trigger     (trigger),
    .cfg_delay   (cfg_delay),
    .cfg_width   (cfg_width),
    .cfg_holdoff (cfg_holdoff),
    .strobe      (strobe),
    .busy        (busy),
    .done        (done),
    .miss_count  (miss_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compares {strobe,busy,done} as one value.
  task automatic chk_out(input string tag, input logic s, input logic b, input logic d);
    chk(tag, {29'd0, strobe, busy, done}, {29'd0, s, b, d});
  endtask

  task automatic chk_miss(input string tag);
    chk(tag, 32'(miss_count), MEN ? 32'(exp_miss) : 32'd0);
  endtask

  task automatic bump_miss();
    if (exp_miss < 255) exp_miss++;
  endtask

  task automatic set_cfg(input int d, input int w, input int h);
    cfg_delay   = CNT_W'(d);
    cfg_width   = CNT_W'(w);
    cfg_holdoff = CNT_W'(h);
  endtask

  // D=3, W=2, H=4 triggered at edge k=i0: strobe after k+3..k+4,
  // busy after k..k+8, done after k+9.
  task automatic run_basic(input string tag);
    set_cfg(3, 2, 4);
    trigger = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      tick();
      trigger = 1'b0;
      chk_out(tag, (i >= 3) && (i <= 4), i <= 8, i == 9);
    end
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b1;
    abort   = 1'b0;
    trigger = 1'b0;
    set_cfg(0, 0, 0);
    #3;
    chk_out("reset_out", 1'b0, 1'b0, 1'b0);
    chk_miss("reset_miss");
    #9;
    reset = 1'b0;
    tick();
    chk_out("post_reset", 1'b0, 1'b0, 1'b0);

    // Basic sequence
    run_basic("basic");

    // D=0, W=1, H=0
    set_cfg(0, 1, 0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    chk_out("w_only_e0", 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("w_only_e1", 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("w_only_e2", 1'b0, 1'b0, 1'b0);

    // D=W=H=0: immediate done, never busy
    set_cfg(0, 0, 0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    chk_out("all_zero_e0", 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("all_zero_e1", 1'b0, 1'b0, 1'b0);

    // Back-to-back with trigger every cycle; period 4 edges, 3 misses each
    set_cfg(1, 1, 1);
    trigger = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ((i % 4) != 0) bump_miss();
      case (i % 4)
        0:       chk_out("b2b_delay", 1'b0, 1'b1, 1'b0);
        1:       chk_out("b2b_strobe", 1'b1, 1'b1, 1'b0);
        2:       chk_out("b2b_hold", 1'b0, 1'b1, 1'b0);
        default: chk_out("b2b_done", 1'b0, 1'b0, 1'b1);
      endcase
      chk_miss("b2b_miss");
    end
    trigger = 1'b0;
    tick();
    chk_out("b2b_idle", 1'b0, 1'b0, 1'b0);
    chk_miss("b2b_miss_final");

    // Abort during the 4th strobe cycle with a same-cycle trigger
    set_cfg(2, 10, 3);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    chk_out("abort_delay0", 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("abort_delay1", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("abort_strobe", 1'b1, 1'b1, 1'b0);
    end
    abort   = 1'b1;
    trigger = 1'b1;
    tick();
    abort   = 1'b0;
    trigger = 1'b0;
    chk_out("abort_cut", 1'b0, 1'b0, 1'b0);
    chk_miss("abort_miss");
    tick();
    chk_out("abort_no_done", 1'b0, 1'b0, 1'b0);

    // cfg_width changed during DELAY must not stretch the strobe
    set_cfg(3, 2, 1);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    chk_out("cfg_e0", 1'b0, 1'b1, 1'b0);
    cfg_width = CNT_W'(9);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk_out("cfg_stable", (i >= 3) && (i <= 4), i <= 5, i == 6);
    end

    // Triggers in IDLE with enable=0 are ignored and not counted
    set_cfg(1, 1, 1);
    enable  = 1'b0;
    trigger = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("disabled_out", 1'b0, 1'b0, 1'b0);
      chk_miss("disabled_miss");
    end
    trigger = 1'b0;

    // Dropping enable mid-sequence: the sequence still completes
    enable  = 1'b1;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    enable  = 1'b0;
    chk_out("en_drop_e0", 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("en_drop_e1", 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("en_drop_e2", 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("en_drop_done", 1'b0, 1'b0, 1'b1);
    enable = 1'b1;
    tick();

    // Saturation: one accepted trigger followed by 259 dropped ones
    set_cfg(100, 100, 100);
    trigger = 1'b1;
    tick();
    for (int i = 0; i < 259; i++) begin
      tick();
      bump_miss();
    end
    trigger = 1'b0;
    chk("sat_model", 32'(exp_miss), 32'd255);
    chk_miss("sat_miss");
    chk_out("sat_busy", 1'b0, 1'b1, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_out("sat_abort", 1'b0, 1'b0, 1'b0);
    chk_miss("sat_hold");

    // Async reset between edges while in STROBE
    set_cfg(2, 5, 2);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    tick();
    tick();
    chk_out("pre_reset_strobe", 1'b1, 1'b1, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    exp_miss = 0;
    chk_out("async_reset_out", 1'b0, 1'b0, 1'b0);
    chk_miss("async_reset_miss");
    #1;
    reset = 1'b0;
    tick();
    chk_out("after_reset_idle", 1'b0, 1'b0, 1'b0);
    run_basic("post_reset_basic");
    chk_miss("post_reset_miss");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
